// File: rtl/mem_bus_arb_pkg.sv
// mem_bus_arb_pkg: arbiter state encoding, master indices and starve counter sizing
package mem_bus_arb_pkg;
    typedef enum logic [1:0] {IDLE, ACCESS, RD_WAIT} state_e;
    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;
    function automatic int starve_w(input int limit);
        return $clog2(limit + 1);
    endfunction
endpackage

// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: one master's request/response channel into the bus arbiter
interface mem_bus_arbiter_if #(
    parameter int ADDR_LENGTH = 32,
    parameter int DATA_LENGTH = 32
);
    logic                   req;
    logic                   we;
    logic [ADDR_LENGTH-1:0] addr;
    logic [DATA_LENGTH-1:0] wdata;
    logic                   gnt;
    logic                   rvalid;
    logic [DATA_LENGTH-1:0] rdata;
    modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
    modport slave (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/arb_starve_guard.sv
// arb_starve_guard: fixed m0 priority with a saturating loss counter that forces m1 through
module arb_starve_guard
    import mem_bus_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req0,
    input  logic req1,
    input  logic arbitrate,
    output logic winner,
    output logic valid
);
    localparam int CW = starve_w(STARVE_LIMIT);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0] starve_cnt_q, starve_cnt_d;

    always_comb begin
        valid = arbitrate && (req0 || req1);
        winner = req1 && (!req0 || starve_cnt_q == LIMIT) ? M1 : M0;
        starve_cnt_d = !valid ? starve_cnt_q : winner == M1 ? '0 : req1 ? starve_cnt_q + CW'(1) : starve_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) starve_cnt_q <= '0;
        else starve_cnt_q <= starve_cnt_d;
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: serialises two masters onto the memory-map bus, one registered transfer at a time
module mem_bus_arbiter
    import mem_bus_arb_pkg::*;
#(
    parameter int ADDR_LENGTH  = 32,
    parameter int DATA_LENGTH  = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    mem_bus_arbiter_if.slave       m0,
    mem_bus_arbiter_if.slave       m1,
    output logic                   bus_MemRead,
    output logic                   bus_MemWrite,
    output logic [ADDR_LENGTH-1:0] bus_Addr,
    output logic [DATA_LENGTH-1:0] bus_DataOut,
    input  logic [DATA_LENGTH-1:0] bus_DataIn,
    output logic                   bus_owner
);
    state_e                 state_q, state_d;
    logic                   owner_q, owner_d, we_q, we_d;
    logic                   rv0_q, rv0_d, rv1_q, rv1_d;
    logic [ADDR_LENGTH-1:0] addr_q, addr_d;
    logic [DATA_LENGTH-1:0] wdata_q, wdata_d, rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic                   arbitrate, winner, valid;

    arb_starve_guard #(.STARVE_LIMIT(STARVE_LIMIT)) u_guard (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0      (m0.req),
        .req1      (m1.req),
        .arbitrate (arbitrate),
        .winner    (winner),
        .valid     (valid)
    );

    always_comb begin
        arbitrate = state_q != ACCESS;
        state_d = state_q == ACCESS ? (we_q ? IDLE : RD_WAIT) : valid ? ACCESS : IDLE;
        owner_d = valid ? winner : owner_q;
        we_d = valid ? (winner == M1 ? m1.we : m0.we) : we_q;
        addr_d = valid ? (winner == M1 ? m1.addr : m0.addr) : addr_q;
        wdata_d = valid ? (winner == M1 ? m1.wdata : m0.wdata) : wdata_q;
        rv0_d = state_q == RD_WAIT && owner_q == M0;
        rv1_d = state_q == RD_WAIT && owner_q == M1;
        rdata0_d = rv0_d ? bus_DataIn : rdata0_q;
        rdata1_d = rv1_d ? bus_DataIn : rdata1_q;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q  <= IDLE;
            owner_q  <= M0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rv0_q    <= 1'b0;
            rv1_q    <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rv0_q    <= rv0_d;
            rv1_q    <= rv1_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end

    // bus drive comes only from registers, never straight from the master inputs
    assign m0.gnt       = state_q == ACCESS && owner_q == M0;
    assign m1.gnt       = state_q == ACCESS && owner_q == M1;
    assign m0.rvalid    = rv0_q;
    assign m1.rvalid    = rv1_q;
    assign m0.rdata     = rdata0_q;
    assign m1.rdata     = rdata1_q;
    assign bus_MemWrite = state_q == ACCESS && we_q;
    assign bus_MemRead  = state_q == ACCESS && !we_q;
    assign bus_Addr     = addr_q;
    assign bus_DataOut  = wdata_q;
    assign bus_owner    = owner_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: vector table, multi-cycle corner sequences and a randomized transaction-model check
module tb_mem_bus_arbiter;
    localparam int LIM = 4;
    localparam int NC = 600;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        bus_MemRead, bus_MemWrite, bus_owner;
    logic [31:0] bus_Addr, bus_DataOut, bus_DataIn;
    logic [31:0] ram [logic [31:0]];
    logic [31:0] mm [logic [31:0]];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;

    mem_bus_arbiter_if i0 ();
    mem_bus_arbiter_if i1 ();

    mem_bus_arbiter #(.STARVE_LIMIT(LIM)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .m0           (i0),
        .m1           (i1),
        .bus_MemRead  (bus_MemRead),
        .bus_MemWrite (bus_MemWrite),
        .bus_Addr     (bus_Addr),
        .bus_DataOut  (bus_DataOut),
        .bus_DataIn   (bus_DataIn),
        .bus_owner    (bus_owner)
    );

    always #5 clk = ~clk;

    // synchronous RAM stand-in: garbage on DataIn unless a read was issued last cycle
    always @(posedge clk) begin
        if (bus_MemWrite) ram[bus_Addr] = bus_DataOut;
        bus_DataIn <= bus_MemRead ? (ram.exists(bus_Addr) ? ram[bus_Addr] : 32'h0) : $urandom();
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h want %h", nm, cyc, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %b want %b", nm, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drv(input int m, input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        if (m == 0) begin
            i0.req = r; i0.we = w; i0.addr = a; i0.wdata = d;
        end else begin
            i1.req = r; i1.we = w; i1.addr = a; i1.wdata = d;
        end
    endtask

    typedef struct {
        int          m;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] ram_init;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t        vt [5];
    logic [31:0] last [2];
    logic        r [2], w [2];
    logic [31:0] a [2], d [2];
    bit          gp [2];
    bit          eg [2][NC+4];
    bit          erv [2][NC+4];
    logic [31:0] erdat [2][NC+4];
    bit          e_rd [NC+4], e_wr [NC+4];
    logic [31:0] e_addr [NC+4], e_dout [NC+4];

    task automatic newtx(input int m);
        r[m] = $urandom_range(0, 9) < 6;
        w[m] = 1'($urandom_range(0, 1));
        a[m] = 32'h1001_0000 | (32'($urandom_range(0, 7)) << 2);
        d[m] = $urandom();
    endtask

    initial begin
        int          m, last_k, g, next_arb, starve, win;
        logic [31:0] mrd [2];
        logic        mown;
        drv(0, 0, 0, 0, 0);
        drv(1, 0, 0, 0, 0);
        tick();
        tick();
        chk1("rst_gnt0", i0.gnt, 0);
        chk1("rst_gnt1", i1.gnt, 0);
        chk1("rst_rv0", i0.rvalid, 0);
        chk1("rst_rv1", i1.rvalid, 0);
        chk1("rst_memrd", bus_MemRead, 0);
        chk1("rst_memwr", bus_MemWrite, 0);
        chk("rst_addr", bus_Addr, 32'h0);
        chk("rst_dout", bus_DataOut, 32'h0);
        chk("rst_rdata0", i0.rdata, 32'h0);
        chk("rst_rdata1", i1.rdata, 32'h0);
        chk1("rst_owner", bus_owner, 0);
        #3 rst_n = 1'b1;
        tick();

        vt[0] = '{0, 1'b0, 32'h0040_0004, 32'h0, 32'h0000_0513, 32'h0000_0513};
        vt[1] = '{1, 1'b1, 32'h1001_0000, 32'hDEAD_BEEF, 32'h0, 32'h0};
        vt[2] = '{1, 1'b0, 32'h1001_0000, 32'h0, 32'h0, 32'hDEAD_BEEF};
        vt[3] = '{0, 1'b0, 32'h2000_0000, 32'h0, 32'h1234_5678, 32'h1234_5678};
        vt[4] = '{1, 1'b0, 32'h2000_0010, 32'h0, 32'hAAAA_5555, 32'hAAAA_5555};
        last[0] = 32'h0;
        last[1] = 32'h0;
        for (int v = 0; v < 5; v++) begin
            m = vt[v].m;
            last_k = vt[v].we ? 2 : 3;
            if (vt[v].ram_init != 32'h0) ram[vt[v].addr] = vt[v].ram_init;
            drv(m, 1, vt[v].we, vt[v].addr, vt[v].wdata);
            chk1("tv_gnt0_k0", i0.gnt, 0);
            chk1("tv_gnt1_k0", i1.gnt, 0);
            for (int k = 1; k <= last_k; k++) begin
                tick();
                if (k == 2) drv(m, 0, vt[v].we, vt[v].addr, vt[v].wdata);
                chk1("tv_gnt0", i0.gnt, k == 1 && m == 0);
                chk1("tv_gnt1", i1.gnt, k == 1 && m == 1);
                chk1("tv_memrd", bus_MemRead, k == 1 && !vt[v].we);
                chk1("tv_memwr", bus_MemWrite, k == 1 && vt[v].we);
                chk1("tv_rv0", i0.rvalid, k == 3 && m == 0);
                chk1("tv_rv1", i1.rvalid, k == 3 && m == 1);
                if (k == 1) begin
                    chk("tv_addr", bus_Addr, vt[v].addr);
                    chk1("tv_owner", bus_owner, m == 1);
                    if (vt[v].we) chk("tv_dout", bus_DataOut, vt[v].wdata);
                end
                if (k == 2 && vt[v].we) chk("tv_commit", ram[vt[v].addr], vt[v].wdata);
                if (k == 3) last[m] = vt[v].exp_rdata;
                chk("tv_rdata0", i0.rdata, last[0]);
                chk("tv_rdata1", i1.rdata, last[1]);
            end
        end

        drv(0, 1, 0, 32'h2000_0000, 32'h0);
        tick();
        chk1("rstmid_gnt", i0.gnt, 1);
        tick();
        drv(0, 0, 0, 32'h2000_0000, 32'h0);
        #2 rst_n = 1'b0;
        #1;
        chk1("rstmid_gnt0", i0.gnt, 0);
        chk1("rstmid_rv0", i0.rvalid, 0);
        chk1("rstmid_memrd", bus_MemRead, 0);
        chk("rstmid_addr", bus_Addr, 32'h0);
        chk("rstmid_rdata0", i0.rdata, 32'h0);
        chk("rstmid_rdata1", i1.rdata, 32'h0);
        chk1("rstmid_owner", bus_owner, 0);
        tick();
        tick();
        #3 rst_n = 1'b1;
        for (int t = 0; t < 3; t++) begin
            tick();
            chk1("rstmid_no_rv0", i0.rvalid, 0);
            chk1("rstmid_no_gnt0", i0.gnt, 0);
        end
        drv(1, 1, 1, 32'h3000_0000, 32'h0000_5555);
        tick();
        chk1("rstmid_first_gnt", i1.gnt, 1);
        tick();
        drv(1, 0, 1, 32'h3000_0000, 32'h0000_5555);
        tick();

        drv(0, 1, 1, 32'h1001_0004, 32'h0000_1111);
        drv(1, 1, 1, 32'h1001_0008, 32'h0000_2222);
        g = 0;
        for (int t = 1; t <= 24; t++) begin
            tick();
            if (i0.gnt || i1.gnt) begin
                chk1("cont_order", i1.gnt, (g % 5) == 4);
                chk1("cont_excl", i0.gnt && i1.gnt, 0);
                g++;
            end
        end
        chk("cont_count", g, 12);
        drv(0, 0, 1, 32'h0, 32'h0);
        drv(1, 0, 1, 32'h0, 32'h0);
        tick();
        tick();
        tick();

        drv(1, 1, 1, 32'h1001_000C, 32'h0000_3333);
        for (int t = 1; t <= 10; t++) begin
            tick();
            chk1("m1_alone_gnt1", i1.gnt, (t % 2) == 1);
            chk1("m1_alone_gnt0", i0.gnt, 0);
        end
        drv(1, 0, 1, 32'h0, 32'h0);
        tick();
        tick();

        rst_n = 1'b0;
        tick();
        #3 rst_n = 1'b1;
        tick();
        ram.delete();
        mm.delete();
        r[0] = 0; r[1] = 0; gp[0] = 0; gp[1] = 0;
        mrd[0] = 32'h0; mrd[1] = 32'h0; mown = 1'b0;
        next_arb = 0;
        starve = 0;
        for (int c = 0; c < NC; c++) begin
            if (c > 0) tick();
            if (eg[0][c]) mown = 1'b0;
            if (eg[1][c]) mown = 1'b1;
            if (erv[0][c]) mrd[0] = erdat[0][c];
            if (erv[1][c]) mrd[1] = erdat[1][c];
            chk1("rnd_gnt0", i0.gnt, eg[0][c]);
            chk1("rnd_gnt1", i1.gnt, eg[1][c]);
            chk1("rnd_rv0", i0.rvalid, erv[0][c]);
            chk1("rnd_rv1", i1.rvalid, erv[1][c]);
            chk("rnd_rdata0", i0.rdata, mrd[0]);
            chk("rnd_rdata1", i1.rdata, mrd[1]);
            chk1("rnd_memrd", bus_MemRead, e_rd[c]);
            chk1("rnd_memwr", bus_MemWrite, e_wr[c]);
            chk1("rnd_owner", bus_owner, mown);
            if (e_rd[c] || e_wr[c]) chk("rnd_addr", bus_Addr, e_addr[c]);
            if (e_wr[c]) chk("rnd_dout", bus_DataOut, e_dout[c]);
            if (!r[0] || gp[0]) newtx(0);
            if (!r[1] || gp[1]) newtx(1);
            gp[0] = i0.gnt;
            gp[1] = i1.gnt;
            drv(0, r[0], w[0], a[0], d[0]);
            drv(1, r[1], w[1], a[1], d[1]);
            if (c >= next_arb && (r[0] || r[1])) begin
                win = (r[0] && r[1]) ? (starve < LIM ? 0 : 1) : (r[1] ? 1 : 0);
                if (win == 1) starve = 0;
                else if (r[1]) starve++;
                eg[win][c+1] = 1;
                e_addr[c+1] = a[win];
                e_dout[c+1] = d[win];
                if (w[win]) begin
                    e_wr[c+1] = 1;
                    mm[a[win]] = d[win];
                end else begin
                    e_rd[c+1] = 1;
                    erv[win][c+3] = 1;
                    erdat[win][c+3] = mm.exists(a[win]) ? mm[a[win]] : 32'h0;
                end
                next_arb = c + 2;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
